// File: rtl/mul_seq.sv
// mul_seq: 32x32 radix-2 shift-add multiplier (MUL/MULH/MULHSU/MULHU)
// with a fixed 34-cycle latency and pipeline stall/flush handshake.
module mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  alu_ctrl,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] prod;
    logic [31:0] mcand;
    logic        neg, low_half;
    logic        valid_op, s1, s2, accept;
    logic [32:0] sum;
    logic [63:0] prod_fix;
    assign valid_op = alu_ctrl >= 5'd17 && alu_ctrl <= 5'd20;
    assign s1       = alu_ctrl == 5'd18 || alu_ctrl == 5'd19;
    assign s2       = alu_ctrl == 5'd18;
    assign accept   = state == IDLE && start && valid_op && !flush;
    assign stall    = rst_n && (accept || state == CALC || state == FIX);
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    // Upper half accumulates the multiplicand; lower half holds the
    // not-yet-consumed multiplier bits and shifts out one per cycle.
    assign sum      = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    assign prod_fix = neg ? -prod : prod;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            prod     <= 64'd0;
            mcand    <= 32'd0;
            neg      <= 1'b0;
            low_half <= 1'b0;
            result   <= 32'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state    <= CALC;
                    cnt      <= 5'd0;
                    mcand    <= s1 && in1[31] ? -in1 : in1;
                    prod     <= {32'd0, s2 && in2[31] ? -in2 : in2};
                    neg      <= (s1 && in1[31]) ^ (s2 && in2[31]);
                    low_half <= alu_ctrl == 5'd17;
                end
                CALC: if (flush) state <= IDLE;
                else begin
                    prod  <= {sum, prod[31:1]};
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd31 ? FIX : CALC;
                end
                FIX: if (flush) state <= IDLE;
                else begin
                    prod   <= prod_fix;
                    result <= low_half ? prod_fix[31:0] : prod_fix[63:32];
                    state  <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: table-driven and scoreboard checks for mul_seq.
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [4:0]  alu_ctrl;
    logic [31:0] in1, in2;
    logic        busy, stall, done;
    logic [31:0] result;
    int          pass_cnt = 0, total_cnt = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t vecs[12];

    mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
        .in1(in1), .in2(in2), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 5'd18 || op == 5'd19) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = op == 5'd18 ? {{32{b[31]}}, b} : {32'd0, b};
        p = ea * eb;
        return op == 5'd17 ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        bit stable;
        logic [31:0] prev, want;
        @(negedge clk);
        alu_ctrl = op; in1 = a; in2 = b; start = 1'b1;
        sb.push_back(exp);
        #1 check({name, "_stall0"}, stall, 1);
        prev = result;
        n = 0; stable = 1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done) break;
            if (result !== prev) stable = 0;
        end
        check({name, "_latency"}, n, 34);
        check({name, "_hold"}, stable, 1);
        want = sb.pop_front();
        check({name, "_result"}, result, want);
    endtask

    initial begin
        vecs[0]  = '{5'd17, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{5'd18, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[5]  = '{5'd17, 32'd0,        32'h12345678, 32'h00000000};
        vecs[6]  = '{5'd18, 32'h80000000, 32'd1,        32'hFFFFFFFF};
        vecs[7]  = '{5'd18, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
        vecs[8]  = '{5'd17, 32'h00010000, 32'h00010000, 32'h00000000};
        vecs[9]  = '{5'd20, 32'h00010000, 32'h00010000, 32'h00000001};
        vecs[10] = '{5'd19, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{5'd20, 32'h00000000, 32'h00000000, 32'h00000000};

        rst_n = 1'b0; start = 1'b1; flush = 1'b0; alu_ctrl = 5'd17; in1 = 32'd3; in2 = 32'd4;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 6; i++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            op = 5'(17 + $urandom_range(3));
            a = $urandom; b = $urandom;
            run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
        end

        begin : restart_ignored
            int n, dones, done_at;
            bit stall_ok;
            @(negedge clk);
            alu_ctrl = 5'd20; in1 = 32'h12345678; in2 = 32'h9ABCDEF0; start = 1'b1;
            sb.push_back(model(5'd20, 32'h12345678, 32'h9ABCDEF0));
            #1 stall_ok = stall;
            dones = 0; done_at = -1;
            for (n = 1; n <= 40; n++) begin
                @(negedge clk);
                start = 1'b0;
                if (n == 5) begin
                    in1 = 32'hFFFFFFFF; in2 = 32'h3; alu_ctrl = 5'd17; start = 1'b1;
                end
                #1;
                if (n <= 33 && !stall) stall_ok = 0;
                if (n == 34 && stall) stall_ok = 0;
                if (done) begin dones++; done_at = n; end
            end
            check("restart_stall", stall_ok, 1);
            check("restart_dones", dones, 1);
            check("restart_done_at", done_at, 34);
            check("restart_result", result, sb.pop_front());
        end

        begin : flush_calc
            int dones;
            logic [31:0] prev;
            prev = result;
            @(negedge clk);
            alu_ctrl = 5'd17; in1 = 32'd5; in2 = 32'd6; start = 1'b1;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                start = 1'b0;
            end
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check("flush_busy", busy, 0);
            dones = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("flush_no_done", dones, 0);
            check("flush_result_kept", result, prev);
            run_op("after_flush", 5'd17, 32'd5, 32'd6, 32'd30);
        end

        @(negedge clk);
        alu_ctrl = 5'd17; start = 1'b1; flush = 1'b1;
        #1 check("idle_flush_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", busy, 0);

        begin : reset_calc
            int dones;
            @(negedge clk);
            alu_ctrl = 5'd18; in1 = 32'hFFFFFFF0; in2 = 32'd9; start = 1'b1;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                start = 1'b0;
            end
            rst_n = 1'b0; start = 1'b1; alu_ctrl = 5'd17;
            #1;
            check("arst_busy", busy, 0);
            check("arst_done", done, 0);
            check("arst_result", result, 0);
            check("arst_stall", stall, 0);
            dones = 0;
            @(negedge clk);
            if (done) dones++;
            rst_n = 1'b1; start = 1'b0;
            alu_ctrl = 5'd5; start = 1'b1;
            #1 check("bad_op_stall", stall, 0);
            for (int n = 0; n < 3; n++) begin
                @(negedge clk);
                if (done) dones++;
                check($sformatf("bad_op_busy%0d", n), busy, 0);
            end
            start = 1'b0;
            check("arst_no_done", dones, 0);
            run_op("after_reset", 5'd19, 32'hFFFFFFF0, 32'd9, model(5'd19, 32'hFFFFFFF0, 32'd9));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
